// File: rtl/matrix_multiply_3x3_sequencer_pkg.sv
// Shared types and constants for the 3x3 matrix-product sequencer and its result buffer.
package matrix_multiply_3x3_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int N      = 3;
  localparam int ELEMS  = 9;
  localparam int PAIRS  = 27;
  localparam int A_BASE = 0;
  localparam int B_BASE = 9;

  function automatic int res_width(input int dw);
    return 2 * dw + 2;
  endfunction

  // Flat row-major element position of [r][c] inside one 3x3 matrix.
  function automatic logic [3:0] elem_idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'(N) + 4'(c);
  endfunction

endpackage

// File: rtl/matrix_multiply_3x3_result_buffer.sv
// Nine-entry result store: written in arrival order by the result count, read by output index.
module matrix_multiply_3x3_result_buffer
  import matrix_multiply_3x3_sequencer_pkg::*;
#(
  parameter int RW = 34
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [3:0]    wr_idx_i,
  input  logic [RW-1:0] wr_data_i,
  input  logic [3:0]    rd_idx_i,
  output logic [RW-1:0] rd_data_o
);

  logic [RW-1:0] mem_q [ELEMS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < ELEMS; e++) begin
        mem_q[e] <= '0;
      end
    end else if (wr_en_i && (wr_idx_i < 4'(ELEMS))) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Reads past the last entry return zero so the prefetch of index 9 is harmless.
  assign rd_data_o = (rd_idx_i < 4'(ELEMS)) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/matrix_multiply_3x3_sequencer.sv
// Feeds A[i][k]/B[k][j] pairs to an external 3-term MAC core, collects the nine
// dot products and streams C row-major over a valid/ready port.
module matrix_multiply_3x3_sequencer
  import matrix_multiply_3x3_sequencer_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = 64,
  localparam int RW     = res_width(DW)
) (
  input  logic                 system1000,
  input  logic                 system1000_rstn,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 err,
  output logic                 core_valid,
  output logic                 core_first,
  output logic                 core_last,
  output logic signed [DW-1:0] core_a,
  output logic signed [DW-1:0] core_b,
  input  logic                 core_res_valid,
  input  logic signed [RW-1:0] core_res,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [RW-1:0] out_data,
  output logic [3:0]           out_index
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [1:0]            i_q, i_d, j_q, j_d, k_q, k_d;
  logic [3:0]            res_cnt_q, res_cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  core_valid_q, core_valid_d;
  logic                  core_first_q, core_first_d;
  logic                  core_last_q, core_last_d;
  logic signed [DW-1:0]  core_a_q, core_a_d, core_b_q, core_b_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [RW-1:0]  out_data_q, out_data_d;
  logic [3:0]            out_index_q, out_index_d;
  logic signed [DW-1:0]  opnd_q [2*ELEMS];
  logic signed [DW-1:0]  opnd_d [2*ELEMS];
  logic                  buf_we;
  logic [3:0]            rd_idx;
  logic [RW-1:0]         rd_data;

  // The pair mux reads opnd_d so a write landing on the start cycle is already visible.
  always_comb begin
    opnd_d = opnd_q;
    if (wr_en && (state_q == IDLE) && (wr_addr < 5'(2 * ELEMS))) begin
      opnd_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int e = 0; e < 2 * ELEMS; e++) begin
        opnd_q[e] <= '0;
      end
    end else begin
      opnd_q <= opnd_d;
    end
  end

  assign rd_idx = (state_q == OUT) ? out_index_q + 4'd1 : 4'd0;

  matrix_multiply_3x3_result_buffer #(
    .RW (RW)
  ) u_result_buffer (
    .clk_i     (system1000),
    .rst_ni    (system1000_rstn),
    .wr_en_i   (buf_we),
    .wr_idx_i  (res_cnt_q),
    .wr_data_i (core_res),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    res_cnt_d    = res_cnt_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    core_valid_d = 1'b0;
    core_first_d = 1'b0;
    core_last_d  = 1'b0;
    core_a_d     = '0;
    core_b_d     = '0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    buf_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ISSUE;
          err_d        = 1'b0;
          i_d          = 2'd0;
          j_d          = 2'd0;
          k_d          = 2'd0;
          res_cnt_d    = 4'd0;
          tmo_d        = '0;
          core_valid_d = 1'b1;
        end
      end
      // i_q/j_q/k_q name the pair currently on the core port; advance k fastest.
      ISSUE: begin
        if ((i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2)) begin
          state_d = DRAIN;
          i_d     = 2'd0;
          j_d     = 2'd0;
          k_d     = 2'd0;
          tmo_d   = '0;
        end else begin
          core_valid_d = 1'b1;
          if (k_q == 2'd2) begin
            k_d = 2'd0;
            if (j_q == 2'd2) begin
              j_d = 2'd0;
              i_d = i_q + 2'd1;
            end else begin
              j_d = j_q + 2'd1;
            end
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      DRAIN: begin
        if (res_cnt_q == 4'(ELEMS)) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_index_d = 4'd0;
          out_data_d  = rd_data;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          if (out_index_q == 4'(ELEMS - 1)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_index_d = 4'd0;
            out_data_d  = '0;
          end else begin
            out_index_d = out_index_q + 4'd1;
            out_data_d  = rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (core_valid_d) begin
      core_a_d     = opnd_d[5'(A_BASE) + 5'(elem_idx(i_d, k_d))];
      core_b_d     = opnd_d[5'(B_BASE) + 5'(elem_idx(k_d, j_d))];
      core_first_d = (k_d == 2'd0);
      core_last_d  = (k_d == 2'd2);
    end

    // Results are only legal while a run is in flight and before the ninth arrives.
    if (core_res_valid) begin
      if (((state_q == ISSUE) || (state_q == DRAIN)) && (res_cnt_q < 4'(ELEMS))) begin
        buf_we    = 1'b1;
        res_cnt_d = res_cnt_q + 4'd1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (wr_en && (state_q != IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q      <= IDLE;
      i_q          <= 2'd0;
      j_q          <= 2'd0;
      k_q          <= 2'd0;
      res_cnt_q    <= 4'd0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      core_valid_q <= 1'b0;
      core_first_q <= 1'b0;
      core_last_q  <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      res_cnt_q    <= res_cnt_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      core_valid_q <= core_valid_d;
      core_first_q <= core_first_d;
      core_last_q  <= core_last_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign core_valid = core_valid_q;
  assign core_first = core_first_q;
  assign core_last  = core_last_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_index  = out_index_q;

endmodule

// File: tb/tb_matrix_multiply_3x3_sequencer.sv
// Scoreboard bench for the 3x3 sequencer, with a 3-cycle MAC core model attached to its core port.
module tb_matrix_multiply_3x3_sequencer;
  import matrix_multiply_3x3_sequencer_pkg::*;

  localparam int DW       = 16;
  localparam int RW       = 2 * DW + 2;
  localparam int CORE_LAT = 3;
  localparam int TIMEOUT  = 64;
  localparam int WAIT_MAX = 400;

  logic                 system1000 = 1'b0;
  logic                 system1000_rstn = 1'b0;
  logic                 wr_en = 1'b0;
  logic [4:0]           wr_addr = '0;
  logic signed [DW-1:0] wr_data = '0;
  logic                 start = 1'b0;
  logic                 busy, err, core_valid, core_first, core_last;
  logic signed [DW-1:0] core_a, core_b;
  logic                 core_res_valid = 1'b0;
  logic signed [RW-1:0] core_res = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [RW-1:0] out_data;
  logic [3:0]           out_index;

  matrix_multiply_3x3_sequencer #(
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .start           (start),
    .busy            (busy),
    .err             (err),
    .core_valid      (core_valid),
    .core_first      (core_first),
    .core_last       (core_last),
    .core_a          (core_a),
    .core_b          (core_b),
    .core_res_valid  (core_res_valid),
    .core_res        (core_res),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_index       (out_index)
  );

  always #5 system1000 = ~system1000;

  int pcyc = 0;
  always @(posedge system1000) pcyc <= pcyc + 1;

  typedef struct { int due; logic signed [RW-1:0] val; } pend_t;
  typedef struct { logic signed [RW-1:0] data; logic [3:0] idx; } exp_t;

  pend_t  pend[$];
  exp_t   sbq[$];
  int     nChecks = 0;
  int     nFail = 0;
  int     pairIdx = 0;
  int     lastRunPairs = 0;
  longint acc = 0;
  bit     mute = 1'b0;
  bit     bpMode = 1'b0;
  int     strayReq = 0;
  int     strayAck = 0;
  int     firstOutCyc = -1;
  int     lastXferCyc = 0;
  int     xfers = 0;
  int     rdyPhase = 0;
  int     lastDriveCyc = 0;
  int     startE = 0;
  int     idleCyc = 0;
  int     matA[9];
  int     matB[9];
  longint expR[9];
  bit     prevValid = 1'b0;
  bit     prevReady = 1'b0;
  logic signed [RW-1:0] prevData = '0;
  logic [3:0] prevIdx = '0;

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, pcyc);
    end
  endtask

  // Core model: products summed over each triple, result presented CORE_LAT cycles after core_last.
  always @(negedge system1000) begin
    if (!system1000_rstn) begin
      pend.delete();
      pairIdx = 0;
      acc = 0;
      strayAck = strayReq;
      core_res_valid = 1'b0;
      core_res = '0;
    end else begin
      core_res_valid = 1'b0;
      core_res = '0;
      if (pend.size() > 0 && pend[0].due == pcyc) begin
        core_res_valid = 1'b1;
        core_res = pend[0].val;
        void'(pend.pop_front());
      end
      if (strayReq != strayAck) begin
        strayAck = strayReq;
        core_res_valid = 1'b1;
        core_res = 34'sd7;
      end
      if (core_valid) begin
        checkOutput("core_first", core_first, (pairIdx % 3) == 0);
        checkOutput("core_last", core_last, (pairIdx % 3) == 2);
        if (core_first) acc = longint'(core_a) * longint'(core_b);
        else            acc = acc + longint'(core_a) * longint'(core_b);
        if (core_last && !mute) pend.push_back('{due: pcyc + CORE_LAT, val: RW'(acc)});
        pairIdx++;
      end else if (pairIdx != 0) begin
        lastRunPairs = pairIdx;
        pairIdx = 0;
      end
    end
  end

  // Monitor: owns out_ready, pops the scoreboard on every accepted transfer.
  always @(negedge system1000) begin
    if (!system1000_rstn) begin
      prevValid = 1'b0;
      rdyPhase = 0;
      out_ready = 1'b1;
    end else begin
      out_ready = bpMode ? (rdyPhase == 0 || rdyPhase == 3) : 1'b1;
      rdyPhase = (rdyPhase + 1) % 4;
      if (out_valid) begin
        if (firstOutCyc < 0) firstOutCyc = pcyc;
        if (prevValid && !prevReady) begin
          checkOutput("stall_data", out_data, prevData);
          checkOutput("stall_index", out_index, prevIdx);
        end
        if (out_ready) begin
          if (sbq.size() == 0) begin
            checkOutput("unexpected_out", out_valid, 0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            checkOutput("out_data", out_data, e.data);
            checkOutput("out_index", out_index, e.idx);
          end
          xfers++;
          lastXferCyc = pcyc;
        end
      end
      prevValid = out_valid;
      prevReady = out_ready;
      prevData = out_data;
      prevIdx = out_index;
    end
  end

  task automatic applyStimulus(input bit we, input logic [4:0] addr,
                               input logic signed [DW-1:0] data, input bit st);
    wr_en = we;
    wr_addr = addr;
    wr_data = data;
    start = st;
    lastDriveCyc = pcyc;
    @(negedge system1000);
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
  endtask

  task automatic loadMatrices();
    for (int r = 0; r < 9; r++) applyStimulus(1'b1, 5'(r), 16'(matA[r]), 1'b0);
    for (int r = 0; r < 9; r++) applyStimulus(1'b1, 5'(9 + r), 16'(matB[r]), 1'b0);
  endtask

  task automatic pushExpected();
    for (int r = 0; r < 9; r++) sbq.push_back('{data: RW'(expR[r]), idx: 4'(r)});
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while ((busy || sbq.size() != 0) && n < WAIT_MAX) begin
      @(negedge system1000);
      n++;
    end
    if (n >= WAIT_MAX) begin
      $display("[TB] %s did not complete", name);
      checkOutput("done_busy", busy, 0);
      checkOutput("done_pending", sbq.size(), 0);
    end
    idleCyc = pcyc;
  endtask

  task automatic runTest(input string name);
    pushExpected();
    firstOutCyc = -1;
    applyStimulus(1'b0, '0, '0, 1'b1);
    startE = lastDriveCyc + 1;
    waitDone(name);
    checkOutput("busy_after_last", idleCyc, lastXferCyc + 1);
  endtask

  task automatic checkAllZero(input string tag);
    $display("[TB] checking quiescent outputs: %s", tag);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_core_valid", core_valid, 0);
    checkOutput("rst_core_first", core_first, 0);
    checkOutput("rst_core_last", core_last, 0);
    checkOutput("rst_core_a", core_a, 0);
    checkOutput("rst_core_b", core_b, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_index", out_index, 0);
  endtask

  initial begin
    repeat (3) @(negedge system1000);
    checkAllZero("power-on reset");
    system1000_rstn = 1'b1;
    @(negedge system1000);

    // Identity times 1..9; B[2][2] arrives in the same cycle as start.
    $display("[TB] identity");
    matA = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    matB = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
    loadMatrices();
    expR = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    pushExpected();
    firstOutCyc = -1;
    applyStimulus(1'b1, 5'd17, 16'sd9, 1'b1);
    startE = lastDriveCyc + 1;
    waitDone("identity");
    checkOutput("first_out_latency", firstOutCyc - startE, 1 + PAIRS + CORE_LAT);
    checkOutput("busy_after_last", idleCyc, lastXferCyc + 1);

    $display("[TB] uniform");
    matA = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    matB = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    loadMatrices();
    expR = '{18, 18, 18, 18, 18, 18, 18, 18, 18};
    runTest("uniform");
    checkOutput("pairs_per_run", lastRunPairs, 27);

    $display("[TB] extremes");
    matA = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    matB = matA;
    loadMatrices();
    for (int r = 0; r < 9; r++) expR[r] = 64'sd3221225472;
    runTest("neg_by_neg");
    matA = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    loadMatrices();
    for (int r = 0; r < 9; r++) expR[r] = -64'sd3221127168;
    runTest("pos_by_neg");

    $display("[TB] backpressure");
    matA = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    matB = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    loadMatrices();
    expR = '{6, 6, 6, 15, 15, 15, 24, 24, 24};
    bpMode = 1'b1;
    xfers = 0;
    runTest("backpressure");
    bpMode = 1'b0;
    checkOutput("transfer_count", xfers, 9);

    $display("[TB] illegal write and start while busy");
    pushExpected();
    applyStimulus(1'b0, '0, '0, 1'b1);
    repeat (5) @(negedge system1000);
    applyStimulus(1'b1, 5'd0, 16'sd99, 1'b1);
    checkOutput("err_on_busy_write", err, 1);
    waitDone("busy_write");
    checkOutput("err_sticky", err, 1);
    pushExpected();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("err_cleared_by_start", err, 0);
    waitDone("err_clear");
    checkOutput("err_stays_clear", err, 0);
    strayReq++;
    repeat (3) @(negedge system1000);
    checkOutput("err_on_stray_result", err, 1);

    $display("[TB] drain timeout");
    mute = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1);
    startE = lastDriveCyc + 1;
    checkOutput("err_cleared_before_timeout", err, 0);
    waitDone("timeout");
    checkOutput("timeout_idle_cycle", idleCyc, startE + PAIRS + TIMEOUT);
    checkOutput("err_on_timeout", err, 1);
    mute = 1'b0;

    $display("[TB] reset during issue");
    applyStimulus(1'b0, '0, '0, 1'b1);
    repeat (8) @(negedge system1000);
    system1000_rstn = 1'b0;
    #1;
    checkAllZero("mid-issue reset");
    repeat (2) @(negedge system1000);
    system1000_rstn = 1'b1;
    repeat (60) @(negedge system1000);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_no_out", out_valid, 0);
    for (int r = 0; r < 9; r++) expR[r] = 0;
    runTest("cleared_operands");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
